// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: two-requester round-robin front end for a shared 4-bit
// operator datapath. One operation is in flight at a time. Multiply takes a
// 4-step shift-add sequence; every other operation finishes in one cycle.
// The result is held on a registered response port until it is consumed.
module alu_op_arbiter #(
  parameter int N_ITER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

  // Odd parity of a 4-bit value.
  function automatic logic par4(input logic [3:0] v);
    return ^v;
  endfunction

  // Single-cycle operators; returns {err, result[7:0]}. MUL is not evaluated here.
  function automatic logic [8:0] alu_eval(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [8:0] r;
    r = 9'd0;
    case (op)
      4'd0:    r = {4'd0, {1'b0, a} + {1'b0, b}};
      4'd1:    r = {4'd0, {1'b0, a} - {1'b0, b}};
      4'd3:    r = {6'd0, (a == b), (a > b), (a < b)};
      4'd4:    r = {8'd0, (|a) & (|b)};
      4'd5:    r = {8'd0, (|a) | (|b)};
      4'd6:    r = {8'd0, par4(a)};
      4'd7:    r = {5'd0, 1'b0, a[3:1]};
      4'd8:    r = {5'd0, a[2:0], 1'b0};
      4'd9:    r = {5'd0, a & b};
      4'd10:   r = {5'd0, a | b};
      4'd11:   r = {5'd0, a ^ b};
      4'd12:   r = {5'd0, ~a};
      4'd13:   r = 9'h100;
      4'd14:   r = 9'h100;
      4'd15:   r = 9'h100;
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_err_q, rsp_err_d;

  logic       idle_s, grant0_s, grant1_s, fire0_s, fire1_s;
  logic [3:0] sel_op_s, sel_a_s, sel_b_s;
  logic [8:0] eval_s;
  logic [7:0] acc_step_s;

  // Round-robin grant: a lone requester wins, a tie goes opposite the last winner.
  always_comb begin
    idle_s   = (state_q == IDLE);
    grant0_s = req0_valid & (~req1_valid | last_grant_q);
    grant1_s = req1_valid & (~req0_valid | ~last_grant_q);
    fire0_s  = req0_valid & req0_ready;
    fire1_s  = req1_valid & req1_ready;
    if (grant1_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
    eval_s     = alu_eval(sel_op_s, sel_a_s, sel_b_s);
    acc_step_s = acc_q + (b_q[cnt_q] ? ({4'd0, a_q} << cnt_q) : 8'd0);
  end

  assign req0_ready = rst_n & idle_s & grant0_s;
  assign req1_ready = rst_n & idle_s & grant1_s;
  assign busy       = ~idle_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

  // Next-state logic for accept, multiply sequencing and response handshake.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (fire0_s | fire1_s) begin
          id_d         = fire1_s;
          last_grant_d = fire1_s;
          a_d          = sel_a_s;
          b_d          = sel_b_s;
          if (sel_op_s == OP_MUL) begin
            acc_d   = 8'd0;
            cnt_d   = 2'd0;
            state_d = MUL;
          end else begin
            rsp_result_d = eval_s[7:0];
            rsp_err_d    = eval_s[8];
            rsp_id_d     = fire1_s;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (cnt_q == CNT_LAST) begin
          acc_d        = acc_step_s;
          rsp_result_d = acc_step_s;
          rsp_err_d    = 1'b0;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          acc_d = acc_step_s;
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      acc_q        <= 8'd0;
      cnt_q        <= 2'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: directed operations with literal expectations plus
// a cycle-level behavioural model checked on every falling edge.
module tb_alu_op_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;

  int total = 0;
  int bad   = 0;

  alu_op_arbiter #(.N_ITER(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Operator semantics in plain arithmetic: returns result + 256*err.
  function automatic int model_f(input int op, input int a, input int b);
    case (op)
      0:  return a + b;
      1:  return (a - b + 32) % 32;
      2:  return a * b;
      3:  return ((a == b) ? 4 : 0) + ((a > b) ? 2 : 0) + ((a < b) ? 1 : 0);
      4:  return (a != 0 && b != 0) ? 1 : 0;
      5:  return (a != 0 || b != 0) ? 1 : 0;
      6:  return $countones(a) % 2;
      7:  return a / 2;
      8:  return (a * 2) % 16;
      9:  return a & b;
      10: return a | b;
      11: return a ^ b;
      12: return 15 - a;
      default: return 256;
    endcase
  endfunction

  // Behavioural model: free / multiply countdown / pending response.
  int  m_left;
  bit  m_rsp, m_last, m_pend_id;
  int  m_res, m_pend;
  bit  mg0, mg1, mfree, me0, me1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rsp = 1'b0; m_left = 0; m_last = 1'b1; m_res = 0; m_pend = 0; m_pend_id = 1'b0;
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end else begin
      mg0   = req0_valid && (!req1_valid || m_last);
      mg1   = req1_valid && (!req0_valid || !m_last);
      mfree = !m_rsp && (m_left == 0);
      me0   = mfree && mg0;
      me1   = mfree && mg1;
      chk("m_ready0", {31'd0, req0_ready}, {31'd0, me0});
      chk("m_ready1", {31'd0, req1_ready}, {31'd0, me1});
      chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp});
      chk("m_busy", {31'd0, busy}, {31'd0, !mfree});
      if (m_rsp) begin
        chk("m_result", {24'd0, rsp_result}, m_res % 256);
        chk("m_err", {31'd0, rsp_err}, m_res / 256);
        chk("m_id", {31'd0, rsp_id}, {31'd0, m_pend_id});
      end
      // what the next rising edge does
      if (m_rsp) begin
        if (rsp_ready) m_rsp = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_rsp = 1'b1;
          m_res = m_pend;
        end
      end else if (me0 || me1) begin
        m_pend_id = me1;
        m_last    = me1;
        if (me1) m_pend = model_f(int'(req1_op), int'(req1_a), int'(req1_b));
        else     m_pend = model_f(int'(req0_op), int'(req0_a), int'(req0_b));
        if ((me1 ? req1_op : req0_op) == 4'd2) begin
          m_left = 4;
        end else begin
          m_rsp = 1'b1;
          m_res = m_pend;
        end
      end
    end
  end

  task automatic drive(input int r, input logic v, input logic [3:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One operation from requester r; checks accept, latency in edges and result.
  task automatic do_op(input int r, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp_res,
                       input logic exp_err, input int exp_edges);
    bit got;
    int n;
    drive(r, 1'b1, op, a, b);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready : req1_ready) got = 1'b1;
    end
    chk("accept_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 drive(r, 1'b0, op, a, b);
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1'b1;
      else begin
        chk("inflight_busy", {31'd0, busy}, 32'd1);
        chk("inflight_ready0", {31'd0, req0_ready}, 32'd0);
        chk("inflight_ready1", {31'd0, req1_ready}, 32'd0);
      end
    end
    chk("rsp_seen", {31'd0, got}, 32'd1);
    chk("rsp_edges", n - 1, exp_edges);
    chk("rsp_result", {24'd0, rsp_result}, {24'd0, exp_res});
    chk("rsp_id", {31'd0, rsp_id}, r);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  int acc_log[$];
  int rid_log[$];
  logic [7:0] held_res;
  bit got_b;

  initial begin
    rst_n = 1'b1; rsp_ready = 1'b1;
    drive(0, 1'b0, 4'd0, 4'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 4'd0, 4'd0);
    #2 rst_n = 1'b0;
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", {24'd0, rsp_result}, 32'd0);
    chk("reset_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_ready0_held_valid", {31'd0, req0_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; req0_valid = 1'b0;

    // pin the model to hand-computed values
    chk("model_add", model_f(0, 15, 15), 32'h1E);
    chk("model_sub", model_f(1, 8, 9), 32'h1F);
    chk("model_mul", model_f(2, 15, 15), 32'hE1);
    chk("model_cmp", model_f(3, 10, 5), 32'h02);
    chk("model_illegal", model_f(13, 3, 4), 32'h100);

    // directed operations
    do_op(0, 4'd0,  4'hF, 4'hF, 8'h1E, 1'b0, 0);
    do_op(0, 4'd1,  4'd8, 4'd9, 8'h1F, 1'b0, 0);
    do_op(1, 4'd2,  4'hF, 4'hF, 8'hE1, 1'b0, 4);
    do_op(1, 4'd2,  4'd9, 4'd0, 8'h00, 1'b0, 4);
    do_op(0, 4'd2,  4'd5, 4'd6, 8'h1E, 1'b0, 4);
    do_op(0, 4'd3,  4'd9, 4'd9, 8'h04, 1'b0, 0);
    do_op(0, 4'd3,  4'd10, 4'd5, 8'h02, 1'b0, 0);
    do_op(1, 4'd3,  4'd2, 4'd7, 8'h01, 1'b0, 0);
    do_op(0, 4'd4,  4'd0, 4'd5, 8'h00, 1'b0, 0);
    do_op(1, 4'd5,  4'd0, 4'd5, 8'h01, 1'b0, 0);
    do_op(0, 4'd6,  4'b1011, 4'd0, 8'h01, 1'b0, 0);
    do_op(0, 4'd7,  4'b1011, 4'd0, 8'h05, 1'b0, 0);
    do_op(0, 4'd8,  4'b1010, 4'd0, 8'h04, 1'b0, 0);
    do_op(1, 4'd9,  4'hC, 4'hA, 8'h08, 1'b0, 0);
    do_op(1, 4'd10, 4'hC, 4'hA, 8'h0E, 1'b0, 0);
    do_op(0, 4'd11, 4'd5, 4'd3, 8'h06, 1'b0, 0);
    do_op(0, 4'd12, 4'd5, 4'd0, 8'h0A, 1'b0, 0);
    do_op(1, 4'd15, 4'd1, 4'd1, 8'h00, 1'b1, 0);

    // fairness: both valid continuously from reset
    apply_reset();
    drive(0, 1'b1, 4'd0, 4'd1, 4'd1);
    drive(1, 1'b1, 4'd0, 4'd2, 4'd2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) acc_log.push_back(0);
      if (req1_valid && req1_ready) acc_log.push_back(1);
      if (rsp_valid && rsp_ready) rid_log.push_back(int'(rsp_id));
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 4'd0, 4'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("rr_accepts", acc_log.size() >= 4, 32'd1);
    chk("rr_responses", rid_log.size() >= 4, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k < acc_log.size()) chk("rr_accept_order", acc_log[k], k % 2);
      if (k < rid_log.size()) chk("rr_rsp_id_order", rid_log[k], k % 2);
    end
    repeat (3) @(posedge clk);
    #1;

    // backpressure with an illegal opcode, other requester waiting
    rsp_ready = 1'b0;
    drive(0, 1'b1, 4'hD, 4'd3, 4'd4);
    got_b = 1'b0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      @(negedge clk);
      if (req0_ready) got_b = 1'b1;
    end
    chk("bp_accept_seen", {31'd0, got_b}, 32'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, 4'hD, 4'd3, 4'd4);
    drive(1, 1'b1, 4'd0, 4'd5, 4'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) held_res = rsp_result;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", {24'd0, rsp_result}, 32'd0);
      chk("bp_result_stable", {24'd0, rsp_result}, {24'd0, held_res});
      chk("bp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_err", {31'd0, rsp_err}, 32'd1);
      chk("bp_no_accept", {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_4th", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    chk("bp_idle_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1 drive(1, 1'b0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;

    // reset two cycles into a multiply
    drive(0, 1'b1, 4'd2, 4'd3, 4'd3);
    got_b = 1'b0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      @(negedge clk);
      if (req0_ready) got_b = 1'b1;
    end
    chk("mr_accept_seen", {31'd0, got_b}, 32'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mr_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    do_op(0, 4'd0, 4'd1, 4'd2, 8'h03, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
